// File: rtl/intc_controller.sv
// intc_controller: prioritised interrupt controller with a vector table and
// control/status registers on a simple addr/wdata/we bus.
// Optional build macro INTC_EDGE_DETECT_EN: when defined, a request is the
// rising edge of done; otherwise done is level-sensitive.
module intc_controller #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SRC    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_SRC-1:0]    done,
    input  logic                  IACK,
    input  logic [DATA_WIDTH-1:0] input_addr,
    input  logic                  write_enable,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  IRQ,
    output logic [DATA_WIDTH-1:0] isr_addr
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_ASSERT   = 2'b01,
        ST_WAIT_REL = 2'b10
    } state_t;

    localparam int IDX_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int WORD_W = DATA_WIDTH - 2;

    logic [DATA_WIDTH-1:0] vector_r [NUM_SRC];
    logic [NUM_SRC-1:0]    enable_r;
    logic [NUM_SRC-1:0]    pending_r;
    state_t                state_r;
    logic [2:0]            id_r;
    logic                  irq_r;
    logic [DATA_WIDTH-1:0] isr_addr_r;

    logic [WORD_W-1:0]     word_s;
    logic [IDX_W-1:0]      vec_idx_s;
    logic                  sel_vec_s;
    logic                  sel_en_s;
    logic                  sel_pend_s;
    logic                  sel_stat_s;
    logic [NUM_SRC-1:0]    event_s;
    logic [NUM_SRC-1:0]    req_s;
    logic [NUM_SRC-1:0]    w1c_s;
    logic [NUM_SRC-1:0]    iack_clr_s;
    logic                  win_found_s;
    logic [2:0]            win_id_s;
    logic                  busy_s;
    logic [DATA_WIDTH-1:0] rdata_s;
    logic                  unused_addr_s;

    // Word-aligned decode; the byte offset bits carry no meaning.
    assign word_s        = input_addr[DATA_WIDTH-1:2];
    assign unused_addr_s = ^input_addr[1:0];
    assign vec_idx_s     = word_s[IDX_W-1:0];
    assign sel_vec_s     = (word_s < WORD_W'(NUM_SRC));
    assign sel_en_s      = (word_s == WORD_W'(8));
    assign sel_pend_s    = (word_s == WORD_W'(9));
    assign sel_stat_s    = (word_s == WORD_W'(10));

`ifdef INTC_EDGE_DETECT_EN
    logic [NUM_SRC-1:0] done_q_r;

    // Delayed copy of done so only a rising edge raises a request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q_r <= '0;
        end else begin
            done_q_r <= done;
        end
    end

    assign event_s = done & ~done_q_r;
`else
    assign event_s = done;
`endif

    assign req_s  = pending_r & enable_r;
    assign busy_s = (state_r == ST_ASSERT) || (state_r == ST_WAIT_REL);

    // Lowest enabled pending index wins (index 0 is highest priority).
    always_comb begin
        win_found_s = 1'b0;
        win_id_s    = 3'b000;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req_s[i]) begin
                win_found_s = 1'b1;
                win_id_s    = 3'(i);
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Pending clear sources: W1C write and the acknowledge of the serviced id.
    always_comb begin
        w1c_s      = '0;
        iack_clr_s = '0;
        if (write_enable && sel_pend_s) begin
            w1c_s = write_data[NUM_SRC-1:0];
        end else begin
            w1c_s = '0;
        end
        if ((state_r == ST_ASSERT) && IACK) begin
            iack_clr_s[id_r[IDX_W-1:0]] = 1'b1;
        end else begin
            iack_clr_s = '0;
        end
    end

    // Vector table, enable mask and pending latch; a new event beats a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                vector_r[i] <= '0;
            end
            enable_r  <= '0;
            pending_r <= '0;
        end else begin
            if (write_enable && sel_vec_s) begin
                vector_r[vec_idx_s] <= write_data;
            end
            if (write_enable && sel_en_s) begin
                enable_r <= write_data[NUM_SRC-1:0];
            end
            pending_r <= (pending_r & ~(w1c_s | iack_clr_s)) | event_s;
        end
    end

    // Service FSM with registered IRQ and vector output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            id_r       <= 3'b000;
            irq_r      <= 1'b0;
            isr_addr_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (win_found_s) begin
                        state_r    <= ST_ASSERT;
                        id_r       <= win_id_s;
                        irq_r      <= 1'b1;
                        isr_addr_r <= vector_r[win_id_s[IDX_W-1:0]];
                    end else begin
                        irq_r      <= 1'b0;
                        isr_addr_r <= '0;
                    end
                end
                ST_ASSERT: begin
                    if (IACK) begin
                        state_r <= ST_WAIT_REL;
                        irq_r   <= 1'b0;
                    end else begin
                        irq_r      <= 1'b1;
                        isr_addr_r <= vector_r[id_r[IDX_W-1:0]];
                    end
                end
                ST_WAIT_REL: begin
                    if (!IACK) begin
                        state_r    <= ST_IDLE;
                        id_r       <= 3'b000;
                        isr_addr_r <= '0;
                    end else begin
                        irq_r <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    id_r       <= 3'b000;
                    irq_r      <= 1'b0;
                    isr_addr_r <= '0;
                end
            endcase
        end
    end

    // Combinational register read; unmapped words return zero.
    always_comb begin
        rdata_s = '0;
        if (sel_vec_s) begin
            rdata_s = vector_r[vec_idx_s];
        end else if (sel_en_s) begin
            rdata_s[NUM_SRC-1:0] = enable_r;
        end else if (sel_pend_s) begin
            rdata_s[NUM_SRC-1:0] = pending_r;
        end else if (sel_stat_s) begin
            rdata_s[3:0] = {busy_s, id_r};
        end else begin
            rdata_s = '0;
        end
    end

    assign read_data = rdata_s;
    assign IRQ       = irq_r;
    assign isr_addr  = isr_addr_r;

endmodule

// File: tb/tb_intc_controller.sv
// Directed self-checking bench for intc_controller (DATA_WIDTH=32, NUM_SRC=4).
module tb_intc_controller;

    logic        clk;
    logic        rst_n;
    logic [3:0]  done;
    logic        IACK;
    logic [31:0] input_addr;
    logic        write_enable;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        IRQ;
    logic [31:0] isr_addr;

    int total = 0;
    int bad   = 0;

    intc_controller #(.DATA_WIDTH(32), .NUM_SRC(4)) dut (
        .clk(clk), .rst_n(rst_n), .done(done), .IACK(IACK),
        .input_addr(input_addr), .write_enable(write_enable),
        .write_data(write_data), .read_data(read_data),
        .IRQ(IRQ), .isr_addr(isr_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        input_addr   = a;
        write_data   = d;
        write_enable = 1'b1;
        tick();
        write_enable = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        input_addr = a;
        #1;
        chk(tag, read_data, exp);
    endtask

    initial begin
        rst_n = 1'b0; done = 4'h0; IACK = 1'b0;
        input_addr = 32'h0; write_enable = 1'b0; write_data = 32'h0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("rst_irq", {31'h0, IRQ}, 32'h0);
        chk("rst_isr", isr_addr, 32'h0);
        rd("rst_status", 32'h28, 32'h0);

        // Basic service of source 2
        wr(32'h08, 32'h0000_0200);
        wr(32'h20, 32'h0000_000F);
        rd("vec2_rb", 32'h08, 32'h200);
        rd("vec2_rb_byteoff", 32'h0B, 32'h200);
        done = 4'b0100; tick(); done = 4'h0;
        rd("basic_pend", 32'h24, 32'h4);
        chk("basic_irq_early", {31'h0, IRQ}, 32'h0);
        tick();
        chk("basic_irq", {31'h0, IRQ}, 32'h1);
        chk("basic_isr", isr_addr, 32'h200);
        rd("basic_status", 32'h28, 32'hA);
        IACK = 1'b1; tick();
        chk("basic_ack_irq", {31'h0, IRQ}, 32'h0);
        chk("basic_ack_isr_hold", isr_addr, 32'h200);
        rd("basic_ack_pend", 32'h24, 32'h0);
        IACK = 1'b0; tick();
        rd("basic_rel_status", 32'h28, 32'h0);
        chk("basic_rel_isr", isr_addr, 32'h0);

        // Priority: sources 1 and 3 together
        wr(32'h04, 32'h0000_0100);
        wr(32'h0C, 32'h0000_0300);
        done = 4'b1010; tick(); done = 4'h0;
        tick();
        chk("prio_first", isr_addr, 32'h100);
        rd("prio_status1", 32'h28, 32'h9);
        IACK = 1'b1; tick(); IACK = 1'b0; tick();
        chk("prio_gap_irq", {31'h0, IRQ}, 32'h0);
        tick();
        chk("prio_second_irq", {31'h0, IRQ}, 32'h1);
        chk("prio_second", isr_addr, 32'h300);
        rd("prio_status2", 32'h28, 32'hB);
        IACK = 1'b1; tick(); IACK = 1'b0; tick();
        rd("prio_pend_empty", 32'h24, 32'h0);

        // Masking, then unmask; clearing ENABLE mid-service keeps IRQ
        wr(32'h00, 32'h0000_00AA);
        wr(32'h20, 32'h0);
        done = 4'b0001; tick(); done = 4'h0;
        tick(); tick();
        chk("mask_irq", {31'h0, IRQ}, 32'h0);
        rd("mask_pend", 32'h24, 32'h1);
        wr(32'h20, 32'h1);
        tick();
        chk("unmask_irq", {31'h0, IRQ}, 32'h1);
        chk("unmask_isr", isr_addr, 32'hAA);
        wr(32'h20, 32'h0);
        wr(32'h24, 32'h1);
        chk("disable_keeps_irq", {31'h0, IRQ}, 32'h1);
        IACK = 1'b1; tick(); IACK = 1'b0; tick();

        // W1C race: set wins over clear
        done = 4'b0011; tick(); done = 4'h0;
        rd("w1c_pre", 32'h24, 32'h3);
        input_addr = 32'h24; write_data = 32'h1; write_enable = 1'b1; done = 4'b0001;
        tick();
        write_enable = 1'b0; done = 4'h0;
        rd("w1c_race", 32'h24, 32'h3);
        wr(32'h24, 32'h3);
        rd("w1c_clear", 32'h24, 32'h0);

        // Unmapped accesses
        wr(32'h30, 32'hFFFF_FFFF);
        rd("unmapped_30", 32'h30, 32'h0);
        rd("unmapped_10", 32'h10, 32'h0);

        // Re-request arriving with IACK is kept and serviced again
        wr(32'h20, 32'hF);
        done = 4'b0100; tick(); done = 4'h0; tick();
        chk("rereq_irq", {31'h0, IRQ}, 32'h1);
        IACK = 1'b1; done = 4'b0100; tick(); done = 4'h0;
        rd("rereq_pend", 32'h24, 32'h4);
        IACK = 1'b0; tick(); tick();
        chk("rereq_irq2", {31'h0, IRQ}, 32'h1);
        chk("rereq_isr2", isr_addr, 32'h200);
        IACK = 1'b1; tick(); IACK = 1'b0; tick();

        // Held-high done on source 1
        done = 4'b0010; tick(); tick();
        chk("hold_irq", {31'h0, IRQ}, 32'h1);
        IACK = 1'b1; tick();
`ifdef INTC_EDGE_DETECT_EN
        rd("hold_pend", 32'h24, 32'h0);
`else
        rd("hold_pend", 32'h24, 32'h2);
`endif
        IACK = 1'b0; tick(); tick();
`ifdef INTC_EDGE_DETECT_EN
        chk("hold_reirq", {31'h0, IRQ}, 32'h0);
        done = 4'h0; tick();
`else
        chk("hold_reirq", {31'h0, IRQ}, 32'h1);
        done = 4'h0;
        IACK = 1'b1; tick(); IACK = 1'b0; tick();
`endif
        rd("hold_pend_end", 32'h24, 32'h0);

        // Asynchronous reset in the middle of a service
        done = 4'b1000; tick(); done = 4'h0; tick();
        chk("prerst_irq", {31'h0, IRQ}, 32'h1);
        #2; rst_n = 1'b0; #1;
        chk("midrst_irq", {31'h0, IRQ}, 32'h0);
        chk("midrst_isr", isr_addr, 32'h0);
        rd("midrst_status", 32'h28, 32'h0);
        rd("midrst_vec", 32'h08, 32'h0);
        rd("midrst_en", 32'h20, 32'h0);
        rd("midrst_pend", 32'h24, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
